// File: rtl/keypad_if.sv
// Keypad scanner pin bundle: row strobes out, column sense in,
// decoded key code, valid pulse and the shifted entry value.
interface keypad_if;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [15:0] value;

   modport master (
      output row, key_code, key_valid, value,
      input  col
   );

   modport slave (
      input  row, key_code, key_valid, value,
      output col
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low row strobe, synchronized
// column sense, press/release debounce, 4-digit shift-in entry register.
module keypad_scanner #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic      clk,
   input logic      rst,
   keypad_if.master kp
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_MAX = BW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   state_t      state_q, state_d;
   logic [3:0]  col_meta_q, col_meta_d;
   logic [3:0]  col_s_q, col_s_d;
   logic [DW-1:0] div_q, div_d;
   logic [BW-1:0] deb_q, deb_d;
   logic [1:0]  ridx_q, ridx_d;
   logic [1:0]  cidx_q, cidx_d;
   logic [3:0]  cap_q, cap_d;
   logic [3:0]  row_q, row_d;
   logic [3:0]  key_code_q, key_code_d;
   logic        key_valid_q, key_valid_d;
   logic [15:0] value_q, value_d;

   logic [1:0]  low_col;
   logic [3:0]  code;

   always_comb begin
      low_col = 2'd0;
      priority case (1'b1)
         !col_s_q[0]: low_col = 2'd0;
         !col_s_q[1]: low_col = 2'd1;
         !col_s_q[2]: low_col = 2'd2;
         !col_s_q[3]: low_col = 2'd3;
         default:     low_col = 2'd0;
      endcase
   end

   always_comb begin
      code = 4'h0;
      case ({ridx_q, cidx_q})
         4'd0:  code = 4'h1;
         4'd1:  code = 4'h2;
         4'd2:  code = 4'h3;
         4'd3:  code = 4'hA;
         4'd4:  code = 4'h4;
         4'd5:  code = 4'h5;
         4'd6:  code = 4'h6;
         4'd7:  code = 4'hB;
         4'd8:  code = 4'h7;
         4'd9:  code = 4'h8;
         4'd10: code = 4'h9;
         4'd11: code = 4'hC;
         4'd12: code = 4'hE;
         4'd13: code = 4'h0;
         4'd14: code = 4'hF;
         default: code = 4'hD;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      col_meta_d  = kp.col;
      col_s_d     = col_meta_q;
      div_d       = div_q;
      deb_d       = deb_q;
      ridx_d      = ridx_q;
      cidx_d      = cidx_q;
      cap_d       = cap_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      value_d     = value_q;
      unique case (state_q)
         SCAN: begin
            if (div_q == DIV_MAX) begin
               div_d = '0;
               if (col_s_q == 4'hF) begin
                  ridx_d = ridx_q + 2'd1;
               end else begin
                  cap_d   = col_s_q;
                  cidx_d  = low_col;
                  deb_d   = '0;
                  state_d = DEBOUNCE;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (col_s_q == cap_q) begin
               if (deb_q == DEB_MAX) begin
                  key_code_d  = code;
                  value_d     = {value_q[11:0], code};
                  key_valid_d = 1'b1;
                  deb_d       = '0;
                  state_d     = HELD;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end else begin
               div_d   = '0;
               state_d = SCAN;
            end
         end
         HELD: begin
            // any low column restarts the release window
            if (col_s_q == 4'hF) begin
               if (deb_q == DEB_MAX) begin
                  deb_d   = '0;
                  div_d   = '0;
                  ridx_d  = ridx_q + 2'd1;
                  state_d = SCAN;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end else begin
               deb_d = '0;
            end
         end
         default: state_d = SCAN;
      endcase
      row_d = ~(4'b0001 << ridx_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCAN;
         col_meta_q  <= 4'hF;
         col_s_q     <= 4'hF;
         div_q       <= '0;
         deb_q       <= '0;
         ridx_q      <= 2'd0;
         cidx_q      <= 2'd0;
         cap_q       <= 4'hF;
         row_q       <= 4'b1110;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         value_q     <= 16'h0000;
      end else begin
         state_q     <= state_d;
         col_meta_q  <= col_meta_d;
         col_s_q     <= col_s_d;
         div_q       <= div_d;
         deb_q       <= deb_d;
         ridx_q      <= ridx_d;
         cidx_q      <= cidx_d;
         cap_q       <= cap_d;
         row_q       <= row_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         value_q     <= value_d;
      end
   end

   assign kp.row       = row_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix keypad model driving the columns,
// scoreboard of expected key codes/values popped on each key_valid.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DC = 8;

   typedef struct packed {
      logic [3:0]  code;
      logic [15:0] value;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] down = 16'h0;
   logic [3:0]  kmap [16];
   logic [15:0] mval = 16'h0;
   logic        prev_kv = 1'b0;
   exp_t        sb [$];
   int          vecs = 0;
   int          errs = 0;
   int          pulses = 0;

   keypad_if kp ();

   keypad_scanner #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .kp (kp)
   );

   always #5 clk = ~clk;

   // key (r,c) lives at bit r*4+c; a column is pulled low only by a
   // pressed key on the row currently strobed
   always_comb begin
      kp.col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (down[r*4+c] && !kp.row[r]) kp.col[c] = 1'b0;
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (kp.key_valid) begin
         pulses++;
         check("kv_single", {31'd0, prev_kv}, 32'd0);
         check("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("key_code", {28'd0, kp.key_code}, {28'd0, e.code});
            check("value", {16'd0, kp.value}, {16'd0, e.value});
         end
      end
      prev_kv = kp.key_valid;
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_key(logic [3:0] code);
      mval = {mval[11:0], code};
      sb.push_back({code, mval});
   endtask

   task automatic wait_row(logic [3:0] t);
      logic [3:0] p;
      bit ok;
      ok = 1'b0;
      p = kp.row;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (kp.row == t && p != t) ok = 1'b1;
         p = kp.row;
      end
      check("wait_row", {31'd0, ok}, 32'd1);
   endtask

   task automatic press(int r, int c);
      down[r*4+c] = 1'b1;
      expect_key(kmap[r*4+c]);
      tick(40);
      down[r*4+c] = 1'b0;
      tick(30);
   endtask

   initial begin
      kmap = '{4'h1, 4'h2, 4'h3, 4'hA,
               4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC,
               4'hE, 4'h0, 4'hF, 4'hD};

      // reset state and free-running row scan
      tick(3);
      check("rst_row", {28'd0, kp.row}, 32'hE);
      check("rst_code", {28'd0, kp.key_code}, 32'h0);
      check("rst_kv", {31'd0, kp.key_valid}, 32'h0);
      check("rst_value", {16'd0, kp.value}, 32'h0);
      rst = 1'b0;
      tick(4);
      check("scan_row1", {28'd0, kp.row}, 32'hD);
      tick(4);
      check("scan_row2", {28'd0, kp.row}, 32'hB);

      // '5' held for a long time: one pulse, row frozen
      down[5] = 1'b1;
      expect_key(4'h5);
      tick(200);
      check("hold_pulses", pulses, 1);
      check("hold_row", {28'd0, kp.row}, 32'hD);
      down[5] = 1'b0;
      tick(30);

      // entry register shifting
      press(0, 0);
      press(0, 1);
      press(0, 2);
      press(1, 0);
      check("val_1234", {16'd0, kp.value}, 32'h1234);
      check("pulses_5", pulses, 5);
      press(0, 3);
      check("val_234a", {16'd0, kp.value}, 32'h234A);
      check("code_a", {28'd0, kp.key_code}, 32'hA);

      // '7' bounce: captured, then aborted before acceptance
      wait_row(4'b1011);
      down[8] = 1'b1;
      tick(3);
      down[8] = 1'b0;
      tick(6);
      check("abort_row_held", {28'd0, kp.row}, 32'hB);
      tick(1);
      check("abort_row_next", {28'd0, kp.row}, 32'h7);
      tick(20);
      check("abort_pulses", pulses, 6);
      check("abort_value", {16'd0, kp.value}, 32'h234A);

      // '2'+'3' together, then a release glitch in HELD
      down[1] = 1'b1;
      down[2] = 1'b1;
      expect_key(4'h2);
      tick(40);
      check("multi_pulses", pulses, 7);
      check("multi_row", {28'd0, kp.row}, 32'hE);
      down[1] = 1'b0;
      down[2] = 1'b0;
      tick(5);
      down[1] = 1'b1;
      tick(1);
      down[1] = 1'b0;
      tick(9);
      check("glitch_row_held", {28'd0, kp.row}, 32'hE);
      tick(1);
      check("glitch_row_next", {28'd0, kp.row}, 32'hD);
      tick(20);
      check("glitch_pulses", pulses, 7);

      // reset in the middle of debouncing '9'
      wait_row(4'b1011);
      down[10] = 1'b1;
      tick(6);
      rst = 1'b1;
      down[10] = 1'b0;
      tick(1);
      rst = 1'b0;
      mval = 16'h0;
      check("mid_rst_row", {28'd0, kp.row}, 32'hE);
      check("mid_rst_value", {16'd0, kp.value}, 32'h0);
      check("mid_rst_kv", {31'd0, kp.key_valid}, 32'h0);
      check("mid_rst_code", {28'd0, kp.key_code}, 32'h0);
      tick(30);
      check("mid_rst_pulses", pulses, 7);

      // entry restarts from zero after reset
      press(3, 2);
      check("post_rst_value", {16'd0, kp.value}, 32'h000F);
      check("post_rst_pulses", pulses, 8);
      check("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
